// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Most ops finish in one cycle; SRL/SLL run on a 1-bit-per-cycle iterative shifter.
module alu_exec_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o,
  output logic                   branch_taken_o,
  output logic                   busy_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_LUI  = 4'b0110;
  localparam logic [3:0] OP_ANDI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_JAL  = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   branch_q, branch_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   left_q, left_d;

  logic                   accept;
  logic                   is_shift;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_branch;
  logic [DATA_WIDTH-1:0]  shift_next;

  assign accept     = in_valid_i && in_ready_o;
  assign is_shift   = (alu_operation_i == OP_SRL) || (alu_operation_i == OP_SLL);
  assign shift_next = left_q ? (shreg_q << 1) : (shreg_q >> 1);

  // Single-cycle result; shifts by zero fall through as a pass-through of b.
  always_comb begin
    alu_res    = a_i + b_i;
    alu_branch = 1'b0;
    case (alu_operation_i)
      OP_ADD, OP_LW, OP_SW: alu_res = a_i + b_i;
      OP_SUB:               alu_res = a_i - b_i;
      OP_OR, OP_ORI:        alu_res = a_i | b_i;
      OP_ANDI, OP_AND:      alu_res = a_i & b_i;
      OP_NOR:               alu_res = ~(a_i | b_i);
      OP_LUI:               alu_res = b_i << 16;
      OP_SRL, OP_SLL:       alu_res = b_i;
      OP_BEQ: begin
        alu_res    = a_i - b_i;
        alu_branch = (a_i == b_i);
      end
      OP_BNE: begin
        alu_res    = a_i - b_i;
        alu_branch = (a_i != b_i);
      end
      OP_JMP, OP_JAL:       alu_res = b_i;
      default:              alu_res = a_i + b_i;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      branch_q <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      branch_q <= branch_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    branch_d = branch_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt_i != '0)) begin
            shreg_d = b_i;
            cnt_d   = shamt_i;
            left_d  = (alu_operation_i == OP_SLL);
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            branch_d = alu_branch;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        shreg_d = shift_next;
        cnt_d   = cnt_q - 1'b1;
        // The last shift lands directly in the result register.
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d = shift_next;
          zero_d   = (shift_next == '0);
          branch_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o     = (state_q == IDLE) && reset;
    out_valid_o    = (state_q == DONE);
    busy_o         = (state_q != IDLE);
    result_o       = result_q;
    zero_o         = zero_q;
    branch_taken_o = branch_q;
  end

endmodule
